// File: rtl/animated_traps.sv
// Spike-row and lava-pool hazard renderer with animated spike tips and a
// sticky player-versus-hazard hit flag.
module animated_traps #(
    parameter int                             COORD_W     = 9,
    parameter int                             NUM_TRAPS   = 4,
    parameter logic [NUM_TRAPS*COORD_W-1:0]   TRAP_X0     = {9'd180, 9'd100, 9'd220, 9'd60},
    parameter logic [NUM_TRAPS*COORD_W-1:0]   TRAP_X1     = {9'd220, 9'd140, 9'd240, 9'd100},
    parameter logic [NUM_TRAPS*COORD_W-1:0]   TRAP_Y      = {9'd123, 9'd123, 9'd183, 9'd183},
    parameter logic [NUM_TRAPS-1:0]           STATIC_MASK = 4'b0000,
    parameter int                             SPIKE_PITCH = 2,
    parameter int                             BASE_LEN    = 3,
    parameter int                             TIP_MAX     = 3,
    parameter int                             STEP_FRAMES = 2,
    parameter int                             HOLD_FRAMES = 4,
    parameter int                             LAVA_X0     = 75,
    parameter int                             LAVA_X1     = 200,
    parameter int                             LAVA_Y0     = 236,
    parameter int                             LAVA_Y1     = 250,
    parameter int                             PLAYER_W    = 8,
    parameter int                             PLAYER_H    = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               enable,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] x_cord,
    input  logic [COORD_W-1:0] y_cord,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    input  logic               hit_clear,
    output logic [2:0]         colour,
    output logic               draw,
    output logic               hit,
    output logic [1:0]         tip_len,
    output logic [1:0]         phase
);

    typedef enum logic [1:0] {
        RETRACTED  = 2'd0,
        EXTENDING  = 2'd1,
        EXTENDED   = 2'd2,
        RETRACTING = 2'd3
    } phase_t;

    localparam int W1      = COORD_W + 1;
    localparam int CNT_MAX = (HOLD_FRAMES > STEP_FRAMES) ? HOLD_FRAMES : STEP_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_FRAMES - 1);
    localparam logic [1:0]       TIP_FULL  = 2'(TIP_MAX);
    localparam logic [1:0]       TIP_NEAR  = 2'(TIP_MAX - 1);

    localparam logic [W1-1:0] LAVA_XL = W1'(LAVA_X0);
    localparam logic [W1-1:0] LAVA_XR = W1'(LAVA_X1);
    localparam logic [W1-1:0] LAVA_YT = W1'(LAVA_Y0);
    localparam logic [W1-1:0] LAVA_YB = W1'(LAVA_Y1);

    phase_t            phase_q;
    logic [1:0]        tipLen_q;
    logic [CNT_W-1:0]  frameCnt_q;
    logic [2:0]        colour_q, colour_d;
    logic              draw_q, draw_d;
    logic              hit_q, hit_d;

    logic [W1-1:0]        xExt, yExt, pxLo, pxHi, pyLo, pyHi;
    logic                 inLava, lavaTouch, hazard;
    logic [NUM_TRAPS-1:0] baseHit, tipHit, tipTouch;

    function automatic logic overlap(
        input logic [W1-1:0] ax0, input logic [W1-1:0] ax1,
        input logic [W1-1:0] ay0, input logic [W1-1:0] ay1,
        input logic [W1-1:0] bx0, input logic [W1-1:0] bx1,
        input logic [W1-1:0] by0, input logic [W1-1:0] by1
    );
        return (ax0 <= bx1) && (ax1 >= bx0) && (ay0 <= by1) && (ay1 >= by0);
    endfunction

    // One extra bit on every coordinate so offsets near the screen edge cannot wrap.
    assign xExt = W1'(x_cord);
    assign yExt = W1'(y_cord);
    assign pxLo = W1'(player_x);
    assign pyLo = W1'(player_y);
    assign pxHi = W1'(player_x) + W1'(PLAYER_W - 1);
    assign pyHi = W1'(player_y) + W1'(PLAYER_H - 1);

    assign inLava    = (xExt >= LAVA_XL) && (xExt <= LAVA_XR) &&
                       (yExt >= LAVA_YT) && (yExt <= LAVA_YB);
    assign lavaTouch = overlap(pxLo, pxHi, pyLo, pyHi, LAVA_XL, LAVA_XR, LAVA_YT, LAVA_YB);

    for (genvar g = 0; g < NUM_TRAPS; g++) begin : g_trap
        localparam logic [W1-1:0] X0      = W1'(TRAP_X0[g*COORD_W +: COORD_W]);
        localparam logic [W1-1:0] X1      = W1'(TRAP_X1[g*COORD_W +: COORD_W]);
        localparam logic [W1-1:0] Y0      = W1'(TRAP_Y[g*COORD_W +: COORD_W]);
        localparam logic [W1-1:0] TIP_TOP = Y0 + W1'(BASE_LEN);

        logic [W1-1:0] len;
        logic [W1-1:0] xOff;
        logic          column;

        assign len    = STATIC_MASK[g] ? W1'(TIP_MAX) : W1'(tipLen_q);
        assign xOff   = xExt - X0;
        assign column = (xExt >= X0) && (xExt <= X1) &&
                        ((xOff % W1'(SPIKE_PITCH)) == '0);

        assign baseHit[g]  = column && (yExt >= Y0) && (yExt < TIP_TOP);
        assign tipHit[g]   = column && (yExt >= TIP_TOP) && (yExt < TIP_TOP + len);
        // Collision uses the whole tip rectangle, gaps between spikes included.
        assign tipTouch[g] = (len != '0) &&
                             overlap(pxLo, pxHi, pyLo, pyHi, X0, X1, TIP_TOP, TIP_TOP + len - 1'b1);
    end

    // Later traps paint over earlier ones, and a tip over its own base.
    always_comb begin
        colour_d = 3'b000;
        draw_d   = 1'b0;
        if (inLava) begin
            colour_d = 3'b100;
            draw_d   = 1'b1;
        end
        for (int i = 0; i < NUM_TRAPS; i++) begin
            if (tipHit[i]) begin
                colour_d = 3'b100;
                draw_d   = 1'b1;
            end else if (baseHit[i]) begin
                colour_d = 3'b000;
                draw_d   = 1'b1;
            end
        end
    end

    assign hazard = lavaTouch || (|tipTouch);

    always_comb begin
        hit_d = hit_q;
        if (frame_tick && hazard) begin
            hit_d = 1'b1;
        end else if (hit_clear) begin
            hit_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            colour_q <= 3'b000;
            draw_q   <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            colour_q <= colour_d;
            draw_q   <= draw_d;
            hit_q    <= hit_d;
        end
    end

    // The frame counter restarts on every phase change and after every tip step.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            phase_q    <= RETRACTED;
            tipLen_q   <= 2'd0;
            frameCnt_q <= '0;
        end else if (frame_tick && enable) begin
            case (phase_q)
                RETRACTED: begin
                    if (frameCnt_q == HOLD_LAST) begin
                        phase_q    <= EXTENDING;
                        frameCnt_q <= '0;
                    end else begin
                        frameCnt_q <= frameCnt_q + 1'b1;
                    end
                end
                EXTENDING: begin
                    if (frameCnt_q == STEP_LAST) begin
                        frameCnt_q <= '0;
                        if (tipLen_q == TIP_NEAR) begin
                            tipLen_q <= TIP_FULL;
                            phase_q  <= EXTENDED;
                        end else begin
                            tipLen_q <= tipLen_q + 2'd1;
                        end
                    end else begin
                        frameCnt_q <= frameCnt_q + 1'b1;
                    end
                end
                EXTENDED: begin
                    if (frameCnt_q == HOLD_LAST) begin
                        phase_q    <= RETRACTING;
                        frameCnt_q <= '0;
                    end else begin
                        frameCnt_q <= frameCnt_q + 1'b1;
                    end
                end
                RETRACTING: begin
                    if (frameCnt_q == STEP_LAST) begin
                        frameCnt_q <= '0;
                        if (tipLen_q == 2'd1) begin
                            tipLen_q <= 2'd0;
                            phase_q  <= RETRACTED;
                        end else begin
                            tipLen_q <= tipLen_q - 2'd1;
                        end
                    end else begin
                        frameCnt_q <= frameCnt_q + 1'b1;
                    end
                end
                default: begin
                    phase_q    <= RETRACTED;
                    tipLen_q   <= 2'd0;
                    frameCnt_q <= '0;
                end
            endcase
        end
    end

    assign colour  = colour_q;
    assign draw    = draw_q;
    assign hit     = hit_q;
    assign tip_len = tipLen_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_animated_traps.sv
// Scoreboard bench for animated_traps: expectations are queued as stimulus is
// driven and compared right after the clock edge that produces them.
module tb_animated_traps;

    logic       clock;
    logic       resetn;
    logic       enable;
    logic       frameTick;
    logic [8:0] xCord, yCord, playerX, playerY;
    logic       hitClear;

    logic [2:0] colourA, colourB;
    logic       drawA, drawB, hitA, hitB;
    logic [1:0] tipLenA, tipLenB, phaseA, phaseB;

    animated_traps dut (
        .clock(clock), .resetn(resetn), .enable(enable), .frame_tick(frameTick),
        .x_cord(xCord), .y_cord(yCord), .player_x(playerX), .player_y(playerY),
        .hit_clear(hitClear), .colour(colourA), .draw(drawA), .hit(hitA),
        .tip_len(tipLenA), .phase(phaseA)
    );

    // Second copy with trap 0 held fully extended.
    animated_traps #(.STATIC_MASK(4'b0001)) dutStatic (
        .clock(clock), .resetn(resetn), .enable(enable), .frame_tick(frameTick),
        .x_cord(xCord), .y_cord(yCord), .player_x(playerX), .player_y(playerY),
        .hit_clear(hitClear), .colour(colourB), .draw(drawB), .hit(hitB),
        .tip_len(tipLenB), .phase(phaseB)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    localparam int K_COLOUR = 0, K_DRAW = 1, K_HIT = 2, K_TIP = 3, K_PHASE = 4,
                   K_COLOURB = 5, K_DRAWB = 6;

    typedef struct {
        string      tag;
        int         kind;
        logic [2:0] exp;
    } sbEntry_t;

    sbEntry_t sbQ[$];
    int       checkCount = 0;
    int       passCount  = 0;
    int       tickNum    = 0;

    task automatic checkOutput(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    function automatic logic [2:0] observe(input int kind);
        case (kind)
            K_COLOUR:  return colourA;
            K_DRAW:    return {2'b00, drawA};
            K_HIT:     return {2'b00, hitA};
            K_TIP:     return {1'b0, tipLenA};
            K_PHASE:   return {1'b0, phaseA};
            K_COLOURB: return colourB;
            K_DRAWB:   return {2'b00, drawB};
            default:   return 3'bxxx;
        endcase
    endfunction

    task automatic expectVal(input string tag, input int kind, input logic [2:0] exp);
        sbEntry_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sbQ.push_back(e);
    endtask

    // Reference animation timeline: tick m (1..20) of each 20-tick period.
    function automatic logic [2:0] tipAt(input int t);
        int m;
        if (t == 0) return 3'd0;
        m = ((t - 1) % 20) + 1;
        if (m <= 5)  return 3'd0;
        if (m <= 7)  return 3'd1;
        if (m <= 9)  return 3'd2;
        if (m <= 15) return 3'd3;
        if (m <= 17) return 3'd2;
        if (m <= 19) return 3'd1;
        return 3'd0;
    endfunction

    function automatic logic [2:0] phaseAt(input int t);
        int m;
        if (t == 0) return 3'd0;
        m = ((t - 1) % 20) + 1;
        if (m <= 3)  return 3'd0;
        if (m <= 9)  return 3'd1;
        if (m <= 13) return 3'd2;
        if (m <= 19) return 3'd3;
        return 3'd0;
    endfunction

    task automatic applyStimulus(input logic tick, input logic en, input logic clr,
                                 input logic [8:0] x, input logic [8:0] y,
                                 input logic [8:0] px, input logic [8:0] py);
        @(negedge clock);
        frameTick = tick;
        enable    = en;
        hitClear  = clr;
        xCord     = x;
        yCord     = y;
        playerX   = px;
        playerY   = py;
    endtask

    task automatic stepEdge();
        sbEntry_t e;
        @(posedge clock);
        #1;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput(e.tag, observe(e.kind), e.exp);
        end
    endtask

    task automatic renderPix(input string tag, input logic [8:0] x, input logic [8:0] y,
                             input logic expDraw, input logic [2:0] expColour, input logic useStatic);
        applyStimulus(1'b0, 1'b0, 1'b0, x, y, 9'd0, 9'd0);
        expectVal({tag, ".draw"}, useStatic ? K_DRAWB : K_DRAW, {2'b00, expDraw});
        expectVal({tag, ".colour"}, useStatic ? K_COLOURB : K_COLOUR, expColour);
        stepEdge();
    endtask

    task automatic tickAnim(input string tag);
        applyStimulus(1'b1, 1'b1, 1'b0, 9'd300, 9'd10, 9'd0, 9'd0);
        tickNum++;
        expectVal($sformatf("%s%0d.tip", tag, tickNum), K_TIP, tipAt(tickNum));
        expectVal($sformatf("%s%0d.phase", tag, tickNum), K_PHASE, phaseAt(tickNum));
        stepEdge();
    endtask

    task automatic hitStep(input string tag, input logic tick, input logic en, input logic clr,
                           input logic [8:0] px, input logic [8:0] py, input logic expHit);
        applyStimulus(tick, en, clr, 9'd300, 9'd10, px, py);
        if (tick && en) tickNum++;
        expectVal({tag, ".hit"}, K_HIT, {2'b00, expHit});
        expectVal({tag, ".tip"}, K_TIP, tipAt(tickNum));
        expectVal({tag, ".phase"}, K_PHASE, phaseAt(tickNum));
        stepEdge();
    endtask

    initial begin
        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 9'd0, 9'd0);
        stepEdge();
        expectVal("reset.colour", K_COLOUR, 3'd0);
        expectVal("reset.draw", K_DRAW, 3'd0);
        expectVal("reset.hit", K_HIT, 3'd0);
        expectVal("reset.tip", K_TIP, 3'd0);
        expectVal("reset.phase", K_PHASE, 3'd0);
        stepEdge();
        resetn = 1'b1;

        // Static picture with tips retracted.
        renderPix("base60", 9'd60, 9'd183, 1'b1, 3'b000, 1'b0);
        renderPix("gap61", 9'd61, 9'd183, 1'b0, 3'b000, 1'b0);
        renderPix("lava", 9'd100, 9'd240, 1'b1, 3'b100, 1'b0);
        renderPix("blank", 9'd300, 9'd10, 1'b0, 3'b000, 1'b0);
        renderPix("staticTip", 9'd62, 9'd188, 1'b1, 3'b100, 1'b1);
        renderPix("animNoTip", 9'd62, 9'd188, 1'b0, 3'b000, 1'b0);

        hitStep("trapNoTip", 1'b1, 1'b0, 1'b0, 9'd58, 9'd180, 1'b0);

        // One full animation period, then into the first extension step.
        for (int i = 0; i < 26; i++) tickAnim("anim");
        for (int i = 0; i < 3; i++) hitStep("disabledTick", 1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 1'b0);

        renderPix("tip1Row187", 9'd62, 9'd187, 1'b0, 3'b000, 1'b0);
        renderPix("tip1Row186", 9'd62, 9'd186, 1'b1, 3'b100, 1'b0);

        hitStep("trapTip", 1'b1, 1'b0, 1'b0, 9'd58, 9'd180, 1'b1);
        hitStep("hitSticky", 1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 1'b1);
        hitStep("hitClear", 1'b0, 1'b0, 1'b1, 9'd0, 9'd0, 1'b0);
        hitStep("setBeatsClear", 1'b1, 1'b0, 1'b1, 9'd58, 9'd180, 1'b1);
        hitStep("hitClear2", 1'b0, 1'b0, 1'b1, 9'd0, 9'd0, 1'b0);

        for (int i = 0; i < 4; i++) tickAnim("extend");
        renderPix("tip3Row186", 9'd62, 9'd186, 1'b1, 3'b100, 1'b0);
        renderPix("tip3Row189", 9'd62, 9'd189, 1'b0, 3'b000, 1'b0);
        renderPix("tip3Row188", 9'd62, 9'd188, 1'b1, 3'b100, 1'b0);

        // Lava hit in every phase of a full period.
        for (int i = 0; i < 20; i++) begin
            hitStep($sformatf("lava%0d", i), 1'b1, 1'b1, 1'b0, 9'd100, 9'd230, 1'b1);
            hitStep($sformatf("lavaClr%0d", i), 1'b0, 1'b0, 1'b1, 9'd100, 9'd230, 1'b0);
        end
        hitStep("lavaMiss", 1'b1, 1'b0, 1'b0, 9'd100, 9'd227, 1'b0);

        // Reach EXTENDING with tip_len=2, latch a hit, then reset on top of a tick.
        for (int i = 0; i < 18; i++) tickAnim("toMid");
        hitStep("preResetHit", 1'b1, 1'b0, 1'b0, 9'd58, 9'd180, 1'b1);
        resetn = 1'b0;
        for (int r = 0; r < 2; r++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 9'd62, 9'd186, 9'd58, 9'd180);
            tickNum = 0;
            expectVal($sformatf("midReset%0d.tip", r), K_TIP, 3'd0);
            expectVal($sformatf("midReset%0d.phase", r), K_PHASE, 3'd0);
            expectVal($sformatf("midReset%0d.hit", r), K_HIT, 3'd0);
            expectVal($sformatf("midReset%0d.colour", r), K_COLOUR, 3'd0);
            expectVal($sformatf("midReset%0d.draw", r), K_DRAW, 3'd0);
            stepEdge();
        end
        resetn = 1'b1;
        tickAnim("postReset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/animated_traps.md
Name: animated_traps

Overview:
Parametrised successor to the fixed-geometry trap renderer. Draws NUM_TRAPS spike rows plus one lava pool for the pixel currently being scanned. Spike tips extend and retract under a frame-driven state machine. Player-versus-hazard collision is detected and latched as a sticky hit flag. The block sits between the VGA pixel scanner, which supplies x_cord/y_cord/frame_tick, and the frame compositor and game-control FSM, which consume colour/draw and hit.

Parameters:
COORD_W, 9, coordinate width
NUM_TRAPS, 4, number of spike rows
TRAP_X0, {9'd180,9'd100,9'd220,9'd60}, packed start x per trap, trap 0 at LSB
TRAP_X1, {9'd220,9'd140,9'd240,9'd100}, packed end x per trap, inclusive
TRAP_Y, {9'd123,9'd123,9'd183,9'd183}, packed top row per trap
STATIC_MASK, 4'b0000, bit i=1 means trap i tip is always TIP_MAX long
SPIKE_PITCH, 2, spike column spacing
BASE_LEN, 3, base rows
TIP_MAX, 3, maximum tip rows
STEP_FRAMES, 2, frame ticks per tip step
HOLD_FRAMES, 4, frame ticks held fully retracted or fully extended
LAVA_X0/LAVA_X1/LAVA_Y0/LAVA_Y1, 75/200/236/250, lava box, inclusive
PLAYER_W/PLAYER_H, 8/8, player bounding box size

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
enable  in  1  animation enable; frame ticks are ignored while low
frame_tick  in  1  one-cycle pulse per frame
x_cord  in  COORD_W  scan pixel x
y_cord  in  COORD_W  scan pixel y
player_x  in  COORD_W  player box top-left x
player_y  in  COORD_W  player box top-left y
hit_clear  in  1  clears hit
colour  out  3  pixel colour, registered
draw  out  1  pixel belongs to a hazard, registered
hit  out  1  sticky collision flag
tip_len  out  2  current animated tip length
phase  out  2  0 RETRACTED, 1 EXTENDING, 2 EXTENDED, 3 RETRACTING

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low. When resetn=0 at an edge: colour=000, draw=0, hit=0, tip_len=0, phase=RETRACTED, frame counter=0.
- Arithmetic: all y+offset sums are computed in COORD_W+1 bits, so there is no wrap.
- Render path, 1-cycle latency: colour/draw at edge N+1 reflect x/y sampled at edge N.
- Per trap i, a pixel is a spike column when x is in [X0,X1] and (x-X0) % SPIKE_PITCH == 0.
- Base region: spike column and y in [Y, Y+BASE_LEN-1]. Output colour 000, draw=1.
- Tip region: spike column and y in [Y+BASE_LEN, Y+BASE_LEN+L-1]. Output colour 100, draw=1. L is TIP_MAX for static traps, tip_len otherwise. L=0 means no tip.
- Lava region: output colour 100, draw=1.
- Priority, lowest to highest: background (000, draw=0), lava, then traps in ascending index. Within a trap, tip beats base.
- Animation advances only on edges where frame_tick=1 and enable=1. A counter counts qualifying ticks within the current phase and resets on every phase change.
  - RETRACTED: on the HOLD_FRAMES-th tick, go to EXTENDING.
  - EXTENDING: on every STEP_FRAMES-th tick, tip_len+1. When tip_len reaches TIP_MAX, go to EXTENDED.
  - EXTENDED: on the HOLD_FRAMES-th tick, go to RETRACTING.
  - RETRACTING: on every STEP_FRAMES-th tick, tip_len-1. When tip_len reaches 0, go to RETRACTED.
  - Full period with defaults: 20 ticks.
- Collision is evaluated on every edge with frame_tick=1, independent of enable.
  - Inputs: player box [px, px+PLAYER_W-1] x [py, py+PLAYER_H-1], and the pre-update tip lengths.
  - Hit condition: the box overlaps the lava box, or overlaps any trap tip rectangle [X0,X1] x tip rows with L>0. The rectangle test ignores pitch.
  - A hit sets hit at that edge.
- hit_clear=1 clears hit. If hit_clear and a new hit occur on the same edge, set wins.
- Reset during any phase returns to the reset state on that edge. Reset dominates every input.

Test Plan:
- Static render: reset, x=60 y=183 -> next cycle draw=1 colour=000. x=61 y=183 -> draw=0. x=100 y=240 -> draw=1 colour=100. x=300 y=10 -> draw=0 colour=000.
- Animation: enable=1, pulse frame_tick 20 times. Tip_len=0 through tick 5. Tick 6 -> 1, tick 8 -> 2, tick 10 -> 3 with phase=2. Tick 14 -> phase=3. Ticks 16/18/20 -> 2/1/0, phase=0. With enable=0, ticks leave tip_len unchanged.
- Tip rendering: with tip_len=3, x=62 y=186 -> colour=100 draw=1 and y=189 -> draw=0. With tip_len=1, x=62 y=187 -> draw=0. With STATIC_MASK=4'b0001 and tip_len=0, x=62 y=188 -> colour=100.
- Trap collision: player=(58,180), tip_len=0, tick -> hit=0. After tip_len=1, tick -> hit=1. Moving the player to (0,0) keeps hit=1. hit_clear -> hit=0. hit_clear concurrent with an overlapping tick -> hit=1.
- Lava collision: player=(100,230) in every phase, tick -> hit=1. Player=(100,227) -> no hit, since the box bottom at 234 is below LAVA_Y0.
- Reset mid-operation: resetn=0 during EXTENDING with tip_len=2 and hit=1 -> next edge tip_len=0, phase=0, hit=0, colour=000, draw=0. Ticks applied while resetn=0 have no effect.
